sccb_slave: RTL and testbench
=============================

# sccb_slave

SCCB (I2C-compatible) responder that answers the camera-control transactions issued by `sccb_master`. It decodes the 7-bit device address, a 16-bit register address and 8-bit data bytes, and exposes them as a simple register-file strobe interface. It serves as the sensor-side register model in system benches and as a configuration port for FPGA-hosted peripherals on the same SCCB bus.

## Interface
- `SLAVE_ADDR`, 7'h3c, 7-bit device address the block responds to.
- `FILTER_LEN`, 4, number of consecutive equal samples required before a filtered line changes. Used only with `SCCB_SLAVE_GLITCH_FILTER_EN`.
- `clk_i` in 1: system clock. Must be at least 20× the SCL frequency.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `scl_i` in 1: SCL pin level.
- `scl_o` out 1: tied 0.
- `scl_oe` out 1: tied 0. The block never stretches the clock.
- `sda_i` in 1: SDA pin level.
- `sda_o` out 1: tied 0. The line is open-drain.
- `sda_oe` out 1: 1 pulls SDA low.
- `reg_addr_o` out 16: current register pointer.
- `wr_en_o` out 1: one-cycle write strobe.
- `wr_data_o` out 8: write data, valid with `wr_en_o`.
- `rd_req_o` out 1: one-cycle read request for `reg_addr_o`.
- `rd_data_i` in 8: read data. Sampled exactly 1 clk after `rd_req_o`.
- `busy_o` out 1: high from an address match until STOP.

## Operation
**Line conditioning**
- SCL and SDA each pass through a 2-FF synchronizer (optional filter, see Configuration).
- Edge detection on the conditioned signals produces `scl_rise` and `scl_fall` pulses.
- START: conditioned SDA falls while SCL is high.
- STOP: conditioned SDA rises while SCL is high.

**Bit timing**
- Bits are sampled on `scl_rise`.
- `sda_oe` is changed only on `scl_fall`.

**FSM states**
- IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.

**Transitions**
- START from any state → DEV. A repeated START is handled the same way.
- STOP from any state → IDLE, with `sda_oe`=0 and `busy_o`=0.
- DEV: shift in 8 bits, MSB first.
  - Bits [7:1] ≠ `SLAVE_ADDR` → IGNORE. No ACK; stay there until START or STOP.
  - Match → DEV_ACK: drive ACK (`sda_oe`=1) for the 9th clock.
  - R/W=0 → AH. R/W=1 → RD.
- AH → AH_ACK → AL → AL_ACK → WR.
  - `reg_addr_o` loads {AH, AL} on the `scl_rise` of the 8th AL bit.
- WR: after the 8th bit, pulse `wr_en_o` for one cycle with `wr_data_o`.
  - Then ACK (WR_ACK).
  - `reg_addr_o` increments on the cycle after `wr_en_o`.
  - → WR for the next byte.
- RD entry: `rd_req_o` pulses on the `scl_rise` of the 9th clock of the DEV byte.
  - `rd_data_i` is captured into the shift register one cycle later.
  - MSB is driven from the following `scl_fall`.
  - A read without a preceding address phase uses the current pointer.
- RD_ACK: on the 9th `scl_rise`, sample the master's ACK.
  - ACK (0): increment the pointer, pulse `rd_req_o` in the next cycle for the new address, → RD.
  - NACK (1): release SDA, → IGNORE until STOP or START.

**Data rules**
- The pointer is 16-bit and wraps 16'hFFFF → 16'h0000.
- A partial byte interrupted by START or STOP is discarded. No strobe is issued.

**Reset values**
- All outputs are 0; `reg_addr_o`=16'h0000; FSM in IDLE.
- Reset mid-transfer releases SDA immediately (asynchronous).
- After reset the block waits for a fresh START.

## Timing
- Pin-to-edge-pulse latency: 3 clk without the filter; 3+`FILTER_LEN` clk with it.
- `sda_oe` changes 1 clk after the `scl_fall` pulse.
- Read turnaround: `rd_req_o` → capture takes 1 clk. The first driven bit follows the next `scl_fall`, which is ≥ 10 clk later given the clock ratio requirement.
- START and STOP take priority over a bit sample in the same cycle.

## Configuration
- `SCCB_SLAVE_GLITCH_FILTER_EN` defined: each synchronized line feeds a counter filter. The output toggles only after `FILTER_LEN` consecutive equal samples, which suppresses spikes shorter than `FILTER_LEN` clk.
- Undefined: synchronizer output is used directly. `FILTER_LEN` is ignored.

## Structure
- `sccb_pkg` holds:
  - the state enum `sccb_slave_state_t`;
  - `SCCB_DEV_ADDR_W`=7, `SCCB_REG_ADDR_W`=16, `SCCB_DATA_W`=8.
- Sub-module `sccb_line_cond`: synchronizer plus optional filter. It is instantiated for SCL and for SDA.

## Test plan
- Write 0x3c, reg 16'h3008, data 8'h82, STOP → four ACKs; `wr_en_o` one pulse with `reg_addr_o`=16'h3008, `wr_data_o`=8'h82; `busy_o` low after STOP.
- Write address 16'h300A, then Sr + read, `rd_data_i`=8'h56, master NACK → bus carries 8'h56; `rd_req_o` one pulse at 16'h300A.
- Burst write of 3 bytes from 16'hFFFF → writes at 16'hFFFF, 16'h0000, 16'h0001.
- Device address 7'h21 → SDA never pulled; no `wr_en_o` or `rd_req_o`; `busy_o` stays 0.
- `rst_n_i` asserted during the 4th data bit → `sda_oe`=0 in the same cycle. A following clean write of 8'hAA to 16'h0010 succeeds.
- With the macro: a 2-clk SCL glitch mid-byte is ignored and the byte is received intact. Without the macro: the same glitch corrupts the bit count, and the block recovers at the next START.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and widths for the SCCB responder.
package sccb_pkg;

    localparam int SCCB_DEV_ADDR_W = 7;
    localparam int SCCB_REG_ADDR_W = 16;
    localparam int SCCB_DATA_W     = 8;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        AH,
        AH_ACK,
        AL,
        AL_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        IGNORE
    } sccb_slave_state_t;

endpackage

// File: rtl/sccb_slave_if.sv
// SCCB pin bundle plus the register-file strobe side of the responder.
interface sccb_slave_if;
    import sccb_pkg::*;

    logic                       scl_i;
    logic                       scl_o;
    logic                       scl_oe;
    logic                       sda_i;
    logic                       sda_o;
    logic                       sda_oe;
    logic [SCCB_REG_ADDR_W-1:0] reg_addr_o;
    logic                       wr_en_o;
    logic [SCCB_DATA_W-1:0]     wr_data_o;
    logic                       rd_req_o;
    logic [SCCB_DATA_W-1:0]     rd_data_i;
    logic                       busy_o;

    modport slave (
        input  scl_i, sda_i, rd_data_i,
        output scl_o, scl_oe, sda_o, sda_oe, reg_addr_o,
               wr_en_o, wr_data_o, rd_req_o, busy_o
    );

    modport master (
        output scl_i, sda_i, rd_data_i,
        input  scl_o, scl_oe, sda_o, sda_oe, reg_addr_o,
               wr_en_o, wr_data_o, rd_req_o, busy_o
    );

endinterface

// File: rtl/sccb_line_cond.sv
// Input conditioning for one SCCB line: 2-FF synchronizer, optionally
// followed by a counter glitch filter (SCCB_SLAVE_GLITCH_FILTER_EN).
// Idle bus level is high, so every stage resets to 1 to avoid fake edges.
module sccb_line_cond #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_o
);

    logic [1:0] sync;

    // two-stage synchronizer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync <= 2'b11;
        else          sync <= {sync[0], line_i};
    end

`ifdef SCCB_SLAVE_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    // A length of 1 needs no counter: the synchronizer output is already it.
    generate
        if (FILT_EN && FILTER_LEN > 1) begin : g_filt
            localparam int CW = $clog2(FILTER_LEN);
            logic [CW-1:0] cnt;
            logic          filt;

            // toggle only after FILTER_LEN consecutive differing samples
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    cnt  <= '0;
                    filt <= 1'b1;
                end else if (sync[1] == filt) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILTER_LEN - 1)) begin
                    filt <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign line_o = filt;
        end else begin : g_direct
            assign line_o = sync[1];
        end
    endgenerate

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes device address, 16-bit register pointer and data
// bytes into a register-file strobe interface. Never stretches SCL; SDA is
// open-drain (only sda_oe moves). Optional glitch filter on both lines is
// enabled with `define SCCB_SLAVE_GLITCH_FILTER_EN.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [SCCB_DEV_ADDR_W-1:0] SLAVE_ADDR = 7'h3c,
    parameter int                         FILTER_LEN = 4
) (
    input logic         clk_i,
    input logic         rst_n_i,
    sccb_slave_if.slave bus
);

    logic scl_c, sda_c, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    sccb_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl_cond (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .line_i(bus.scl_i), .line_o(scl_c)
    );
    sccb_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda_cond (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .line_i(bus.sda_i), .line_o(sda_c)
    );

    // previous conditioned levels for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_c;
            sda_q <= sda_c;
        end
    end

    assign scl_rise  =  scl_c & ~scl_q;
    assign scl_fall  = ~scl_c &  scl_q;
    assign start_det =  scl_c &  scl_q &  sda_q & ~sda_c;
    assign stop_det  =  scl_c &  scl_q & ~sda_q &  sda_c;

    sccb_slave_state_t          state;
    logic [3:0]                 bit_cnt;
    logic [SCCB_DATA_W-1:0]     shreg, addr_hi, wr_data, byte_in;
    logic [SCCB_REG_ADDR_W-1:0] reg_addr;
    logic                       rw, sda_oe_q, wr_en, rd_req, rd_cap, busy;

    assign byte_in = {shreg[6:0], sda_c};

    // protocol FSM; START/STOP override any bit activity in the same cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            addr_hi  <= '0;
            wr_data  <= '0;
            reg_addr <= '0;
            rw       <= 1'b0;
            sda_oe_q <= 1'b0;
            wr_en    <= 1'b0;
            rd_req   <= 1'b0;
            rd_cap   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            rd_req <= 1'b0;
            rd_cap <= rd_req;
            // pointer advances the cycle after each write strobe
            if (wr_en)  reg_addr <= reg_addr + 16'd1;
            // read data is taken one cycle after the request
            if (rd_cap) shreg <= bus.rd_data_i;

            if (start_det) begin
                state    <= DEV;
                bit_cnt  <= '0;
                sda_oe_q <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                sda_oe_q <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    DEV, AH, AL, WR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                case (state)
                                    DEV: begin
                                        if (byte_in[7:1] == SLAVE_ADDR) begin
                                            state <= DEV_ACK;
                                            busy  <= 1'b1;
                                            rw    <= byte_in[0];
                                        end else begin
                                            state <= IGNORE;
                                        end
                                    end
                                    AH: begin
                                        addr_hi <= byte_in;
                                        state   <= AH_ACK;
                                    end
                                    AL: begin
                                        reg_addr <= {addr_hi, byte_in};
                                        state    <= AL_ACK;
                                    end
                                    default: begin
                                        wr_en   <= 1'b1;
                                        wr_data <= byte_in;
                                        state   <= WR_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    DEV_ACK, AH_ACK, AL_ACK, WR_ACK: begin
                        // read turnaround starts on the ACK clock's rising edge
                        if (scl_rise && state == DEV_ACK && rw) rd_req <= 1'b1;
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                bit_cnt  <= '0;
                                sda_oe_q <= 1'b0;
                                case (state)
                                    DEV_ACK: begin
                                        if (rw) begin
                                            state    <= RD;
                                            sda_oe_q <= ~shreg[7];
                                        end else begin
                                            state <= AH;
                                        end
                                    end
                                    AH_ACK:  state <= AL;
                                    default: state <= WR;
                                endcase
                            end
                        end
                    end
                    RD: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b0};
                                sda_oe_q <= ~shreg[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_c) begin
                                reg_addr <= reg_addr + 16'd1;
                                rd_req   <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall) begin
                            state    <= RD;
                            bit_cnt  <= '0;
                            sda_oe_q <= ~shreg[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.scl_o      = 1'b0;
    assign bus.scl_oe     = 1'b0;
    assign bus.sda_o      = 1'b0;
    assign bus.sda_oe     = sda_oe_q;
    assign bus.reg_addr_o = reg_addr;
    assign bus.wr_en_o    = wr_en;
    assign bus.wr_data_o  = wr_data;
    assign bus.rd_req_o   = rd_req;
    assign bus.busy_o     = busy;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-banged SCCB master, strobe scoreboard.
module tb_sccb_slave;

    localparam int QT = 10;  // clk per quarter SCL period

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic m_scl, m_sda;
    int   total = 0;
    int   bad = 0;
    int   oe_cnt = 0;
    int   busy_cnt = 0;
    int   oe0, busy0;
    logic [31:0] exp_q[$];
    logic        ack;
    logic [7:0]  rbyte;
    logic        b;

    always #5 clk_i = ~clk_i;

    sccb_slave_if bus();

    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    // register-file model: registered response to each read request
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          bus.rd_data_i <= 8'h00;
        else if (bus.rd_req_o) bus.rd_data_i <= bus.reg_addr_o[7:0] ^ 8'h5C;
    end

    sccb_slave dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic rd, input logic [15:0] a, input logic [7:0] d);
        return {7'd0, rd, a, d};
    endfunction

    task automatic monitor();
        logic [31:0] obs;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                if (bus.sda_oe) oe_cnt++;
                if (bus.busy_o) busy_cnt++;
                if (bus.wr_en_o || bus.rd_req_o) begin
                    obs = bus.wr_en_o ? ev(1'b0, bus.reg_addr_o, bus.wr_data_o)
                                      : ev(1'b1, bus.reg_addr_o, 8'h00);
                    if (exp_q.size() == 0) chk("sb_unexpected", obs, 32'hFFFF_FFFF);
                    else                   chk("sb_strobe", obs, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic qwait();
        repeat (QT) @(negedge clk_i);
    endtask

    task automatic sbit(input logic bi, input logic glitch, output logic bo);
        m_sda = bi;
        qwait();
        m_scl = 1'b1;
        qwait();
        bo = bus.sda_i;
        if (glitch) begin
            m_scl = 1'b0;
            repeat (2) @(negedge clk_i);
            m_scl = 1'b1;
        end
        qwait();
        m_scl = 1'b0;
        qwait();
    endtask

    task automatic do_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic do_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
    endtask

    task automatic tx_byte(input logic [7:0] d, input int gbit, output logic a);
        logic x;
        for (int i = 0; i < 8; i++) sbit(d[7-i], i == gbit, x);
        sbit(1'b1, 1'b0, a);
    endtask

    task automatic rx_byte(input logic nack, output logic [7:0] d);
        logic x;
        for (int i = 0; i < 8; i++) begin
            sbit(1'b1, 1'b0, x);
            d[7-i] = x;
        end
        sbit(nack, 1'b0, x);
    endtask

    // START, device write, register address, n data bytes (no STOP)
    task automatic write_regs(input logic [15:0] a, input int n,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        logic       k;
        d[0] = d0; d[1] = d1; d[2] = d2;
        do_start();
        tx_byte(8'h78, -1, k);  chk("ack_dev", {31'd0, k}, 32'd0);
        tx_byte(a[15:8], -1, k); chk("ack_ah", {31'd0, k}, 32'd0);
        tx_byte(a[7:0], -1, k);  chk("ack_al", {31'd0, k}, 32'd0);
        for (int i = 0; i < n; i++) begin
            tx_byte(d[i], -1, k); chk("ack_data", {31'd0, k}, 32'd0);
        end
    endtask

    initial begin
        fork monitor(); join_none
        rst_n_i = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_addr", {16'd0, bus.reg_addr_o}, 32'd0);
        chk("rst_strobes", {30'd0, bus.wr_en_o, bus.rd_req_o}, 32'd0);
        chk("rst_scl", {29'd0, bus.scl_oe, bus.scl_o, bus.sda_o}, 32'd0);
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // single write
        exp_q.push_back(ev(1'b0, 16'h3008, 8'h82));
        write_regs(16'h3008, 1, 8'h82, 8'h00, 8'h00);
        chk("busy_mid", {31'd0, bus.busy_o}, 32'd1);
        do_stop();
        qwait();
        chk("busy_stop", {31'd0, bus.busy_o}, 32'd0);

        // pointer set, repeated START, single read with NACK
        exp_q.push_back(ev(1'b1, 16'h300A, 8'h00));
        write_regs(16'h300A, 0, 8'h00, 8'h00, 8'h00);
        do_start();
        tx_byte(8'h79, -1, ack); chk("ack_rd_dev", {31'd0, ack}, 32'd0);
        rx_byte(1'b1, rbyte);    chk("rd_byte", {24'd0, rbyte}, 32'h56);
        do_stop();
        chk("rd_ptr", {16'd0, bus.reg_addr_o}, 32'h300A);

        // read burst from current pointer: ACK then NACK
        exp_q.push_back(ev(1'b1, 16'h300A, 8'h00));
        exp_q.push_back(ev(1'b1, 16'h300B, 8'h00));
        do_start();
        tx_byte(8'h79, -1, ack); chk("ack_rd2_dev", {31'd0, ack}, 32'd0);
        rx_byte(1'b0, rbyte);    chk("rd2_byte0", {24'd0, rbyte}, 32'h56);
        rx_byte(1'b1, rbyte);    chk("rd2_byte1", {24'd0, rbyte}, 32'h57);
        do_stop();
        chk("rd2_ptr", {16'd0, bus.reg_addr_o}, 32'h300B);

        // burst write across the pointer wrap
        exp_q.push_back(ev(1'b0, 16'hFFFF, 8'h11));
        exp_q.push_back(ev(1'b0, 16'h0000, 8'h22));
        exp_q.push_back(ev(1'b0, 16'h0001, 8'h33));
        write_regs(16'hFFFF, 3, 8'h11, 8'h22, 8'h33);
        do_stop();
        chk("wrap_ptr", {16'd0, bus.reg_addr_o}, 32'h0002);

        // foreign device address: no ACK, no strobe, never busy
        oe0 = oe_cnt;
        busy0 = busy_cnt;
        do_start();
        tx_byte(8'h42, -1, ack); chk("nack_foreign", {31'd0, ack}, 32'd1);
        tx_byte(8'h30, -1, ack);
        do_stop();
        chk("foreign_oe", oe_cnt - oe0, 32'd0);
        chk("foreign_busy", busy_cnt - busy0, 32'd0);

        // reset in the 4th data bit of a read of 8'h00 (SDA held low)
        exp_q.push_back(ev(1'b1, 16'h005C, 8'h00));
        write_regs(16'h005C, 0, 8'h00, 8'h00, 8'h00);
        do_start();
        tx_byte(8'h79, -1, ack); chk("ack_rst_dev", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) sbit(1'b1, 1'b0, b);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        chk("oe_before_rst", {31'd0, bus.sda_oe}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("oe_async_rst", {31'd0, bus.sda_oe}, 32'd0);
        chk("busy_async_rst", {31'd0, bus.busy_o}, 32'd0);
        chk("addr_async_rst", {16'd0, bus.reg_addr_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        m_scl = 1'b0; qwait();
        do_stop();
        exp_q.push_back(ev(1'b0, 16'h0010, 8'hAA));
        write_regs(16'h0010, 1, 8'hAA, 8'h00, 8'h00);
        do_stop();

        // 2-clk SCL glitch in the 4th data bit of 8'h5A
`ifdef SCCB_SLAVE_GLITCH_FILTER_EN
        exp_q.push_back(ev(1'b0, 16'h0020, 8'h5A));
`else
        // the duplicated '1' shifts in as 0101_1_101
        exp_q.push_back(ev(1'b0, 16'h0020, 8'h5D));
`endif
        write_regs(16'h0020, 0, 8'h00, 8'h00, 8'h00);
        tx_byte(8'h5A, 3, ack);
        do_stop();
        exp_q.push_back(ev(1'b0, 16'h0030, 8'h3C));
        write_regs(16'h0030, 1, 8'h3C, 8'h00, 8'h00);
        do_stop();
        chk("final_ptr", {16'd0, bus.reg_addr_o}, 32'h0031);

        repeat (20) @(negedge clk_i);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
